// File: rtl/coin_timer_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// coin_timer_ctrl_pkg
// Shared definitions for the coin-operated session timer:
//   - state_e        : controller state encoding
//   - CAP_MODE1      : credit ceiling (seconds) when the latched mode is 1
//   - CAP_DEFAULT    : credit ceiling (seconds) for every other mode
//   - MODE_ONE       : encoding of the short-session mode
//   - cap_for()      : ceiling lookup for a mode
//   - sat_add()      : add seconds to a credit, clamping at a ceiling
// Build option: COIN_TIMER_PAUSE_EN adds the PAUSED state.
// ----------------------------------------------------------------------------
package coin_timer_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CREDIT  = 3'd1,
        ST_RUNNING = 3'd2,
`ifdef COIN_TIMER_PAUSE_EN
        ST_PAUSED  = 3'd3,
`endif
        ST_DONE    = 3'd4
    } state_e;

    localparam logic [9:0] CAP_MODE1   = 10'd119;
    localparam logic [9:0] CAP_DEFAULT = 10'd599;
    localparam logic [3:0] MODE_ONE    = 4'd1;

    function automatic logic [9:0] cap_for(input logic [3:0] mode);
        return (mode == MODE_ONE) ? CAP_MODE1 : CAP_DEFAULT;
    endfunction

    // The sum is formed at 32 bits so a large per-coin credit cannot wrap
    // the 10-bit credit before it is compared with the ceiling.
    function automatic logic [9:0] sat_add(input logic [9:0]  base,
                                           input int unsigned add,
                                           input logic [9:0]  cap);
        int unsigned sum;
        sum = {22'd0, base} + add;
        return (sum > {22'd0, cap}) ? cap : sum[9:0];
    endfunction

endpackage

// File: rtl/coin_timer_ctrl_tick_gen.sv
// ----------------------------------------------------------------------------
// tick_gen
// One-second prescaler. Counts 0..TICK_DIV-1 while Run is high and holds its
// value while Run is low, so a paused session resumes mid-second.
// Ports:
//   Clk      in  clock
//   nReset   in  synchronous active-low reset (count returns to 0)
//   Run      in  advance the count this cycle
//   Restart  in  force the count back to 0 (takes priority over Run)
//   Tick     out high during the terminal-count cycle while Run is high
// ----------------------------------------------------------------------------
module tick_gen #(
    parameter int unsigned TICK_DIV = 50000000
) (
    input  logic Clk,
    input  logic nReset,
    input  logic Run,
    input  logic Restart,
    output logic Tick
);

    localparam int unsigned    CW   = $clog2(TICK_DIV);
    localparam logic [CW-1:0]  TERM = CW'(TICK_DIV - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (Restart) begin
            count_d = '0;
        end else if (Run) begin
            count_d = (count_q == TERM) ? '0 : count_q + CW'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (!nReset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign Tick = Run && (count_q == TERM);

endmodule

// File: rtl/coin_timer_ctrl.sv
// ----------------------------------------------------------------------------
// coin_timer_ctrl
// Coin-credited countdown controller. Coins buy COIN_SECONDS each (clamped
// at a mode-dependent ceiling), Start runs the countdown at one second per
// TICK_DIV clocks, Cancel aborts, and Done pulses once when credit runs out.
// Build option: define COIN_TIMER_PAUSE_EN to let Pause toggle
// RUNNING <-> PAUSED; otherwise Pause is ignored.
// Ports:
//   Clk             in   clock
//   nReset          in   synchronous active-low reset
//   CoinIn          in   one-cycle coin-accepted pulse
//   ModeSel[3:0]    in   mode, latched on the first coin of a session
//   Start           in   begin countdown (from CREDIT)
//   Cancel          in   abort the session
//   Pause           in   one-cycle pause/resume toggle
//   CounterInput    out  latched mode
//   CounterEnable   out  one-cycle advance strobe, once per second tick
//   CounterClear_n  out  active-low one-cycle clear (reset, session start)
//   Remaining[9:0]  out  remaining seconds
//   Busy            out  high whenever not IDLE
//   Done            out  one-cycle expiry pulse
// ----------------------------------------------------------------------------
module coin_timer_ctrl
    import coin_timer_ctrl_pkg::*;
#(
    parameter int unsigned TICK_DIV     = 50000000,
    parameter int unsigned COIN_SECONDS = 60
) (
    input  logic       Clk,
    input  logic       nReset,
    input  logic       CoinIn,
    input  logic [3:0] ModeSel,
    input  logic       Start,
    input  logic       Cancel,
    input  logic       Pause,
    output logic [3:0] CounterInput,
    output logic       CounterEnable,
    output logic       CounterClear_n,
    output logic [9:0] Remaining,
    output logic       Busy,
    output logic       Done
);

    state_e     state_q, state_d;
    logic [9:0] rem_q, rem_d;
    logic [3:0] mode_q, mode_d;
    logic       clr_n_q, clr_n_d;
    logic       tick;
    logic       restart;
    logic [9:0] cap;

`ifndef COIN_TIMER_PAUSE_EN
    logic pause_unused;
    assign pause_unused = Pause;
`endif

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .Clk     (Clk),
        .nReset  (nReset),
        .Run     (state_q == ST_RUNNING),
        .Restart (restart),
        .Tick    (tick)
    );

    // State register
    always_ff @(posedge Clk) begin
        if (!nReset) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            mode_q  <= '0;
            clr_n_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            mode_q  <= mode_d;
            clr_n_q <= clr_n_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        mode_d  = mode_q;
        clr_n_d = 1'b1;
        restart = 1'b0;
        cap     = cap_for(mode_q);

        case (state_q)
            ST_IDLE: begin
                if (CoinIn) begin
                    state_d = ST_CREDIT;
                    mode_d  = ModeSel;
                    // Ceiling comes from the mode being latched now.
                    rem_d   = sat_add(10'd0, COIN_SECONDS, cap_for(ModeSel));
                    clr_n_d = 1'b0;
                end
            end

            ST_CREDIT: begin
                if (Cancel) begin
                    state_d = ST_IDLE;
                    rem_d   = '0;
                end else begin
                    if (CoinIn) begin
                        rem_d = sat_add(rem_q, COIN_SECONDS, cap);
                    end
                    if (Start) begin
                        state_d = ST_RUNNING;
                        restart = 1'b1;
                    end
                end
            end

            ST_RUNNING: begin
                if (Cancel) begin
                    state_d = ST_IDLE;
                    rem_d   = '0;
                end else begin
                    if (tick) begin
                        if (CoinIn) begin
                            rem_d = sat_add(rem_q - 10'd1, COIN_SECONDS, cap);
                        end else begin
                            rem_d = rem_q - 10'd1;
                            if (rem_q == 10'd1) begin
                                state_d = ST_DONE;
                            end
                        end
                    end else if (CoinIn) begin
                        rem_d = sat_add(rem_q, COIN_SECONDS, cap);
                    end
`ifdef COIN_TIMER_PAUSE_EN
                    // Expiry wins over a same-cycle pause request.
                    if (Pause && state_d == ST_RUNNING) begin
                        state_d = ST_PAUSED;
                    end
`endif
                end
            end

`ifdef COIN_TIMER_PAUSE_EN
            ST_PAUSED: begin
                if (Cancel) begin
                    state_d = ST_IDLE;
                    rem_d   = '0;
                end else begin
                    if (CoinIn) begin
                        rem_d = sat_add(rem_q, COIN_SECONDS, cap);
                    end
                    if (Pause) begin
                        state_d = ST_RUNNING;
                    end
                end
            end
`endif

            ST_DONE: begin
                state_d = ST_IDLE;
                rem_d   = '0;
            end

            default: begin
                state_d = ST_IDLE;
                rem_d   = '0;
            end
        endcase
    end

    // Output logic
    always_comb begin
        Busy          = (state_q != ST_IDLE);
        Done          = (state_q == ST_DONE);
        // tick is only ever high in RUNNING; Cancel suppresses the strobe.
        CounterEnable = tick && (state_q == ST_RUNNING) && !Cancel;
    end

    assign CounterInput   = mode_q;
    assign CounterClear_n = clr_n_q;
    assign Remaining      = rem_q;

endmodule

// File: tb/tb_coin_timer_ctrl.sv
module tb_coin_timer_ctrl;

    logic       Clk = 1'b0;
    logic       nReset = 1'b0;
    logic       CoinIn = 1'b0;
    logic [3:0] ModeSel = 4'd0;
    logic       Start = 1'b0;
    logic       Cancel = 1'b0;
    logic       Pause = 1'b0;
    logic [3:0] CounterInput;
    logic       CounterEnable;
    logic       CounterClear_n;
    logic [9:0] Remaining;
    logic       Busy;
    logic       Done;

    int checks = 0;
    int failures = 0;

    coin_timer_ctrl #(
        .TICK_DIV     (4),
        .COIN_SECONDS (60)
    ) dut (
        .Clk            (Clk),
        .nReset         (nReset),
        .CoinIn         (CoinIn),
        .ModeSel        (ModeSel),
        .Start          (Start),
        .Cancel         (Cancel),
        .Pause          (Pause),
        .CounterInput   (CounterInput),
        .CounterEnable  (CounterEnable),
        .CounterClear_n (CounterClear_n),
        .Remaining      (Remaining),
        .Busy           (Busy),
        .Done           (Done)
    );

    always #5 Clk = ~Clk;

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Coin (first of session) then Start; returns with RUNNING and prescaler at 0.
    task automatic begin_session(input logic [3:0] mode);
        ModeSel = mode; CoinIn = 1'b1; step(); CoinIn = 1'b0;
        Start = 1'b1; step(); Start = 1'b0;
    endtask

    task automatic end_session();
        Cancel = 1'b1; step(); Cancel = 1'b0; step();
    endtask

    task automatic test_reset();
        nReset = 1'b0; step();
        checks++; if (Remaining !== 10'd0) begin failures++; $display("FAIL reset_rem actual=%0d required=0", Remaining); end
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL reset_busy actual=%b required=0", Busy); end
        checks++; if (Done !== 1'b0) begin failures++; $display("FAIL reset_done actual=%b required=0", Done); end
        checks++; if (CounterEnable !== 1'b0) begin failures++; $display("FAIL reset_cen actual=%b required=0", CounterEnable); end
        checks++; if (CounterClear_n !== 1'b0) begin failures++; $display("FAIL reset_clr actual=%b required=0", CounterClear_n); end
        checks++; if (CounterInput !== 4'd0) begin failures++; $display("FAIL reset_mode actual=%0d required=0", CounterInput); end
        nReset = 1'b1; step();
        checks++; if (CounterClear_n !== 1'b1) begin failures++; $display("FAIL reset_clr_release actual=%b required=1", CounterClear_n); end
        $display("test_reset done");
    endtask

    task automatic test_countdown();
        int exp_rem;
        logic exp_ce, exp_done, exp_busy;
        ModeSel = 4'd1; CoinIn = 1'b1; step(); CoinIn = 1'b0;
        checks++; if (Remaining !== 10'd60) begin failures++; $display("FAIL cd_first_coin actual=%0d required=60", Remaining); end
        checks++; if (CounterClear_n !== 1'b0) begin failures++; $display("FAIL cd_clear actual=%b required=0", CounterClear_n); end
        checks++; if (CounterInput !== 4'd1) begin failures++; $display("FAIL cd_mode actual=%0d required=1", CounterInput); end
        checks++; if (Busy !== 1'b1) begin failures++; $display("FAIL cd_busy actual=%b required=1", Busy); end
        step();
        checks++; if (CounterClear_n !== 1'b1 || CounterEnable !== 1'b0) begin failures++; $display("FAIL cd_credit_idle clr=%b cen=%b required clr=1 cen=0", CounterClear_n, CounterEnable); end
        Start = 1'b1; step(); Start = 1'b0;
        for (int k = 0; k <= 241; k++) begin
            exp_ce   = (k % 4 == 3) && (k < 240);
            exp_rem  = (k < 240) ? 60 - k / 4 : 0;
            exp_done = (k == 240);
            exp_busy = (k <= 240);
            checks++;
            if (CounterEnable !== exp_ce || Remaining !== 10'(exp_rem) || Done !== exp_done || Busy !== exp_busy) begin
                failures++;
                $display("FAIL cd_cycle%0d actual cen=%b rem=%0d done=%b busy=%b required cen=%b rem=%0d done=%b busy=%b",
                         k, CounterEnable, Remaining, Done, Busy, exp_ce, exp_rem, exp_done, exp_busy);
            end
            if (k < 241) step();
        end
        checks++; if (CounterInput !== 4'd1) begin failures++; $display("FAIL cd_mode_hold actual=%0d required=1", CounterInput); end
        $display("test_countdown done");
    endtask

    task automatic test_saturation();
        int exp_rem;
        ModeSel = 4'd1; CoinIn = 1'b1; step();
        checks++; if (Remaining !== 10'd60) begin failures++; $display("FAIL sat_m1_c1 actual=%0d required=60", Remaining); end
        ModeSel = 4'd2; step();
        checks++; if (Remaining !== 10'd119) begin failures++; $display("FAIL sat_m1_c2 actual=%0d required=119", Remaining); end
        step(); CoinIn = 1'b0;
        checks++; if (Remaining !== 10'd119) begin failures++; $display("FAIL sat_m1_c3 actual=%0d required=119", Remaining); end
        checks++; if (CounterInput !== 4'd1) begin failures++; $display("FAIL sat_mode_ignored actual=%0d required=1", CounterInput); end
        Cancel = 1'b1; step(); Cancel = 1'b0;
        checks++; if (Remaining !== 10'd0 || Busy !== 1'b0 || Done !== 1'b0) begin failures++; $display("FAIL sat_cancel rem=%0d busy=%b done=%b required 0 0 0", Remaining, Busy, Done); end
        ModeSel = 4'd2; CoinIn = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            step();
            exp_rem = (60 * n > 599) ? 599 : 60 * n;
            checks++; if (Remaining !== 10'(exp_rem)) begin failures++; $display("FAIL sat_m2_c%0d actual=%0d required=%0d", n, Remaining, exp_rem); end
        end
        CoinIn = 1'b0;
        checks++; if (CounterInput !== 4'd2) begin failures++; $display("FAIL sat_mode2 actual=%0d required=2", CounterInput); end
        end_session();
        $display("test_saturation done");
    endtask

    task automatic test_coin_on_last_tick();
        int done_seen = 0;
        begin_session(4'd0);
        // k=0 now; step to k=239 (last tick cycle with Remaining=1)
        for (int k = 1; k <= 239; k++) begin
            step();
            if (Done === 1'b1) done_seen++;
        end
        checks++; if (Remaining !== 10'd1 || CounterEnable !== 1'b1) begin failures++; $display("FAIL lt_setup rem=%0d cen=%b required rem=1 cen=1", Remaining, CounterEnable); end
        CoinIn = 1'b1; step(); CoinIn = 1'b0;
        checks++; if (Remaining !== 10'd60 || Busy !== 1'b1) begin failures++; $display("FAIL lt_coin rem=%0d busy=%b required rem=60 busy=1", Remaining, Busy); end
        for (int k = 0; k < 4; k++) begin
            step();
            if (Done === 1'b1) done_seen++;
        end
        checks++; if (Remaining !== 10'd59) begin failures++; $display("FAIL lt_continue actual=%0d required=59", Remaining); end
        checks++; if (done_seen !== 0) begin failures++; $display("FAIL lt_no_done actual=%0d required=0", done_seen); end
        end_session();
        $display("test_coin_on_last_tick done");
    endtask

    task automatic test_cancel();
        int bad = 0;
        begin_session(4'd3);
        step(); step(); step();   // k=3: tick cycle
        Cancel = 1'b1; CoinIn = 1'b1; step(); Cancel = 1'b0; CoinIn = 1'b0;
        checks++; if (Remaining !== 10'd0 || Busy !== 1'b0 || Done !== 1'b0) begin failures++; $display("FAIL cancel_state rem=%0d busy=%b done=%b required 0 0 0", Remaining, Busy, Done); end
        for (int k = 0; k < 12; k++) begin
            if (CounterEnable !== 1'b0 || Done !== 1'b0 || Remaining !== 10'd0) bad++;
            step();
        end
        checks++; if (bad !== 0) begin failures++; $display("FAIL cancel_quiet bad_cycles=%0d required=0", bad); end
        $display("test_cancel done");
    endtask

    task automatic test_pause();
`ifdef COIN_TIMER_PAUSE_EN
        int bad = 0;
        begin_session(4'd0);
        step();                               // k=1
        Pause = 1'b1; step(); Pause = 1'b0;   // paused, prescaler frozen at 2
        for (int k = 0; k < 20; k++) begin
            if (CounterEnable !== 1'b0 || Remaining !== 10'd60 || Busy !== 1'b1) bad++;
            step();
        end
        checks++; if (bad !== 0) begin failures++; $display("FAIL pause_hold bad_cycles=%0d required=0", bad); end
        Pause = 1'b1; step(); Pause = 1'b0;
        checks++; if (CounterEnable !== 1'b0) begin failures++; $display("FAIL pause_resume0 actual=%b required=0", CounterEnable); end
        step();
        checks++; if (CounterEnable !== 1'b1 || Remaining !== 10'd60) begin failures++; $display("FAIL pause_resume_tick cen=%b rem=%0d required cen=1 rem=60", CounterEnable, Remaining); end
        step();
        checks++; if (Remaining !== 10'd59) begin failures++; $display("FAIL pause_resume_dec actual=%0d required=59", Remaining); end
`else
        begin_session(4'd0);
        step();                               // k=1
        Pause = 1'b1; step(); Pause = 1'b0;   // k=2, must be ignored
        step();                               // k=3
        checks++; if (CounterEnable !== 1'b1) begin failures++; $display("FAIL pause_ignored_tick actual=%b required=1", CounterEnable); end
        step();
        checks++; if (Remaining !== 10'd59) begin failures++; $display("FAIL pause_ignored_dec actual=%0d required=59", Remaining); end
`endif
        end_session();
        $display("test_pause done");
    endtask

    task automatic test_reset_mid_run();
        int done_seen = 0;
        begin_session(4'd5);
        for (int k = 0; k < 5; k++) step();
        nReset = 1'b0; step();
        checks++; if (Remaining !== 10'd0 || Busy !== 1'b0 || Done !== 1'b0 || CounterEnable !== 1'b0) begin failures++; $display("FAIL rst_mid_outputs rem=%0d busy=%b done=%b cen=%b required 0 0 0 0", Remaining, Busy, Done, CounterEnable); end
        checks++; if (CounterClear_n !== 1'b0 || CounterInput !== 4'd0) begin failures++; $display("FAIL rst_mid_counter clr=%b mode=%0d required clr=0 mode=0", CounterClear_n, CounterInput); end
        nReset = 1'b1; step();
        checks++; if (CounterClear_n !== 1'b1 || Busy !== 1'b0) begin failures++; $display("FAIL rst_mid_release clr=%b busy=%b required clr=1 busy=0", CounterClear_n, Busy); end
        for (int k = 0; k < 8; k++) begin
            if (Done === 1'b1 || CounterEnable === 1'b1) done_seen++;
            step();
        end
        checks++; if (done_seen !== 0) begin failures++; $display("FAIL rst_mid_quiet actual=%0d required=0", done_seen); end
        $display("test_reset_mid_run done");
    endtask

    initial begin
        test_reset();
        test_countdown();
        test_saturation();
        test_coin_on_last_tick();
        test_cancel();
        test_pause();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
